// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time base: FSM encoding, digit width and
// default wrap limits of the four display digits.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam int TENTHS_LIM_DEF   = 10;
  localparam int SEC_ONES_LIM_DEF = 10;
  localparam int SEC_TENS_LIM_DEF = 6;
  localparam int MIN_LIM_DEF      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_lim_digit.sv
// One display digit: increments on carry-in, wraps to 0 at LIM and reports a
// combinational carry-out so digits can be chained within a single cycle.
module lim_digit
  import stopwatch_pkg::*;
#(
  parameter int LIM = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               ci,
  output logic [DIGIT_W-1:0] d,
  output logic               co
);

  logic [DIGIT_W-1:0] d_q, d_d;
  logic [DIGIT_W:0]   sum;

  // Sum is one bit wider so the compare against LIM cannot alias on overflow.
  always_comb begin
    sum = {1'b0, d_q} + {{DIGIT_W{1'b0}}, ci};
    d_d = d_q;
    if (clr) begin
      d_d = '0;
    end else if (sum == (DIGIT_W+1)'(LIM)) begin
      d_d = '0;
    end else begin
      d_d = sum[DIGIT_W-1:0];
    end
  end

  assign co = ci && (d_q == DIGIT_W'(LIM - 1));
  assign d  = d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch time base: start/pause/clear FSM, tenth-second prescaler and the
// chained M:SS.T digit registers feeding the display driver.
//
//   state    | meaning
//   ST_IDLE  | cleared, prescaler held at 0, waiting for start_stop
//   ST_RUN   | prescaler counting, tick advances the digit chain
//   ST_PAUSE | prescaler and digits frozen, residual count kept
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV      = 10000000,
  parameter int TENTHS_LIM   = TENTHS_LIM_DEF,
  parameter int SEC_ONES_LIM = SEC_ONES_LIM_DEF,
  parameter int SEC_TENS_LIM = SEC_TENS_LIM_DEF,
  parameter int MIN_LIM      = MIN_LIM_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_stop,
  input  logic               clear,
  output logic [DIGIT_W-1:0] tenths,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] minutes,
  output logic               running,
  output logic               rollover
);

  localparam int PW = $clog2(CLK_DIV);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            roll_q, roll_d;
  logic            tick;
  logic            co_tenths, co_ones, co_tens, co_min;

  assign tick = (state_q == ST_RUN) && (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (start_stop) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Pause holds the prescaler so a resumed interval finishes its partial tenth.
  always_comb begin
    presc_d = presc_q;
    if (clear || (state_q == ST_IDLE)) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  assign roll_d = co_min && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      roll_q  <= roll_d;
    end
  end

  lim_digit #(.LIM(TENTHS_LIM)) u_tenths (
    .clk(clk), .reset_n(reset_n), .clr(clear), .ci(tick),
    .d(tenths), .co(co_tenths)
  );

  lim_digit #(.LIM(SEC_ONES_LIM)) u_sec_ones (
    .clk(clk), .reset_n(reset_n), .clr(clear), .ci(co_tenths),
    .d(sec_ones), .co(co_ones)
  );

  lim_digit #(.LIM(SEC_TENS_LIM)) u_sec_tens (
    .clk(clk), .reset_n(reset_n), .clr(clear), .ci(co_ones),
    .d(sec_tens), .co(co_tens)
  );

  lim_digit #(.LIM(MIN_LIM)) u_minutes (
    .clk(clk), .reset_n(reset_n), .clr(clear), .ci(co_tens),
    .d(minutes), .co(co_min)
  );

  assign running  = (state_q == ST_RUN);
  assign rollover = roll_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch time base.
- Runs a start/pause/clear state machine and an internal prescaler that produces a count-enable tick.
- The tick drives a ripple chain of four limited-increment digit registers: tenths 0-9, seconds-ones 0-9, seconds-tens 0-5, minutes 0-9.
- Sits between the debounced button pulses and the 7-segment display driver.

Parameters:
- CLK_DIV, 10000000: clock cycles per tenth-second tick (100 MHz -> 10 Hz). Must be >= 2.
- TENTHS_LIM, 10: wrap limit of the tenths digit.
- SEC_ONES_LIM, 10: wrap limit of the seconds-ones digit.
- SEC_TENS_LIM, 6: wrap limit of the seconds-tens digit.
- MIN_LIM, 10: wrap limit of the minutes digit.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start_stop, in, 1: one-cycle pulse (debounced upstream); toggles run/pause.
- clear, in, 1: one-cycle pulse; zeroes the time and returns to IDLE.
- tenths, out, 4: tenths-of-second digit.
- sec_ones, out, 4: seconds units digit.
- sec_tens, out, 4: seconds tens digit.
- minutes, out, 4: minutes digit.
- running, out, 1: high while in the RUN state.
- rollover, out, 1: one-cycle pulse when the display wraps from 9:59.9 to 0:00.0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE.
  - Prescaler = 0.
  - All digits = 0.
  - running = 0, rollover = 0.
- State machine states: IDLE, RUN, PAUSE. The state encoding is registered and running is decoded from it.
  - IDLE, start_stop -> RUN.
  - RUN, start_stop -> PAUSE.
  - PAUSE, start_stop -> RUN.
  - Any state, clear -> IDLE.
- Clear and start_stop high in the same cycle: clear wins. Next state is IDLE and everything is zeroed.
- Clear effect: on the next edge, digits = 0, prescaler = 0, rollover = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while in RUN.
  - Holds its value in PAUSE, so a resumed interval keeps its residual count.
  - Zeroed in IDLE and on clear.
- Tick: combinational, tick = (state==RUN) && (prescaler==CLK_DIV-1). The prescaler returns to 0 on the same edge.
- Latency from IDLE:
  - start_stop is sampled at edge E; running goes high after E.
  - The first tenths increment occurs at edge E+CLK_DIV.
- Digit chain, per digit:
  - carry_in(tenths) = tick.
  - carry_in(next digit) = carry_out(previous digit).
  - next value = (d + ci == LIM) ? 0 : d + ci.
  - carry_out = ci && (d == LIM-1).
  - The chain is fully combinational within one cycle; all digits update on the same edge.
- Arithmetic: 4-bit digits; the internal d + ci is computed 5 bits wide. A digit register never holds a value >= its LIM.
- Rollover: registered pulse, high for exactly the one cycle after the edge on which the minutes carry_out was 1 (9:59.9 -> 0:00.0). The counter continues running after rollover.
- start_stop arriving on the same cycle as tick in RUN:
  - That tick's increment is still applied.
  - The state then moves to PAUSE.
- Tick and clear in the same cycle: clear wins; no increment is applied.
- Reset asserted mid-run: immediate return to the reset values, with no dependency on clk.
- Outputs come straight from registers; there is no glitching combinational path to the display.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2;
  - the default digit limits;
  - DIGIT_W=4.
- Sub-module lim_digit, parameter LIM:
  - inputs clk, reset_n, clr, ci;
  - outputs d[3:0], co (combinational);
  - holds one digit register with limited increment and wrap.
- stopwatch_ctrl instantiates four lim_digit instances plus the FSM and the prescaler.

Test Plan (all scenarios use CLK_DIV=4):
- Reset held, then released -> all digits 0, running=0, rollover=0; no change over 20 idle cycles without start_stop.
- start_stop pulse at edge E -> running=1 after E; tenths=1 after E+4, tenths=2 after E+8. The 10th tick gives tenths=0 and sec_ones=1.
- Run 16 ticks, then pulse start_stop -> PAUSE. Digits frozen at 0:01.6 for 50 cycles. A second start_stop resumes, and the next increment arrives after the residual prescaler count, not a full 4 cycles.
- Force the count to 9:59.8 by running 5998 ticks, then 2 more ticks -> 9:59.9 then 0:00.0. rollover is high for exactly one cycle and running stays 1.
- Pulse clear and start_stop in the same cycle while in RUN at 0:03.2 -> next state IDLE, digits 0, running=0.
- Assert reset_n low asynchronously between clock edges while running at 0:12.5 -> outputs go to 0 immediately. After release, the block stays in IDLE until start_stop.
